// File: rtl/fifo_arb_pkg.sv
// Shared types and elaboration helpers for the async FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping modulo N.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  // Duplicating the vector lets a plain right shift act as a rotate.
  assign doubled = {req, req};
  assign rotated = N'(doubled >> rr_ptr);
  assign found   = |req;

  always_comb begin
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IW'(k);
    end
  end

  assign sum   = {1'b0, rr_ptr} + {1'b0, offset};
  assign index = (sum >= N_EXT) ? IW'(sum - N_EXT) : sum[IW-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port among NUM_REQ valid/ready producers using
// round-robin grants of at most MAX_BURST beats; never writes while full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     wr_clk,
  input  logic                     wr_reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] gidx_reg, gidx_next;
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;

  logic          in_burst;
  logic          owner_valid;
  logic          beat;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] gidx_inc;
  logic [WIDTH-1:0] data_arr [NUM_REQ];

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .index  (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
      assign grant[gi]     = in_burst && (gidx_reg == IW'(gi));
      assign req_ready[gi] = beat && (gidx_reg == IW'(gi));
    end
  endgenerate

  // Full gates the write in the same cycle, so the FIFO can never overflow.
  assign in_burst    = (state_reg == BURST);
  assign owner_valid = req_valid[gidx_reg];
  assign beat        = in_burst && owner_valid && !full;
  assign wr_en       = beat;
  assign busy        = in_burst;
  assign in          = in_burst ? data_arr[gidx_reg] : '0;
  assign gidx_inc    = IW'(mod_inc(32'(gidx_reg), NUM_REQ));

  always_comb begin
    state_next     = state_reg;
    gidx_next      = gidx_reg;
    burst_cnt_next = burst_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          gidx_next      = pick_idx;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        // A dropped valid forfeits the grant; a full FIFO only stalls it.
        if (!owner_valid) begin
          state_next  = IDLE;
          rr_ptr_next = gidx_inc;
        end else if (beat && (burst_cnt_reg == LAST_BEAT)) begin
          state_next  = IDLE;
          rr_ptr_next = gidx_inc;
        end else if (beat) begin
          burst_cnt_next = burst_cnt_reg + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state_reg     <= IDLE;
      gidx_reg      <= '0;
      burst_cnt_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      gidx_reg      <= gidx_next;
      burst_cnt_reg <= burst_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario tests plus a randomized run scored against a rule-level model of
// the round-robin burst arbiter and per-producer word queues.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                     wr_clk;
  logic                     wr_reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     full;
  logic                     wr_en;
  logic [WIDTH-1:0]         in;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;

  logic [WIDTH-1:0] pdata [NUM_REQ];

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_reset_n (wr_reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .wr_en      (wr_en),
    .in         (in),
    .grant      (grant),
    .busy       (busy)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
      assign req_data[gi*WIDTH +: WIDTH] = pdata[gi];
    end
  endgenerate

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    wr_reset_n = 1'b0;
    full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 wr_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_grant;
    logic [7:0] exp_in;
    logic       exp_wr;
    req_valid = 4'b1111;
    full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'h10 + 8'(i);
    wr_reset_n = 1'b0;
    repeat (2) @(negedge wr_clk);
    checks++;
    if (grant !== 4'b0000 || wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || in !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: grant=%b wr_en=%b ready=%b busy=%b in=%h required all zero", grant, wr_en, req_ready, busy, in);
    end
    @(posedge wr_clk);
    #1 wr_reset_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge wr_clk);
      exp_wr    = (c >= 1 && c <= 4) || (c == 6);
      exp_grant = (c == 0 || c == 5) ? 4'b0000 : (c == 6 ? 4'b0010 : 4'b0001);
      exp_in    = (c == 0 || c == 5) ? 8'h00 : (c == 6 ? 8'h11 : 8'h10);
      checks++;
      if (grant !== exp_grant || wr_en !== exp_wr || in !== exp_in ||
          req_ready !== (exp_wr ? exp_grant : 4'b0000)) begin
        errors++;
        $display("FAIL reset_release c%0d: grant=%b wr_en=%b in=%h ready=%b required grant=%b wr_en=%b in=%h",
                 c, grant, wr_en, in, req_ready, exp_grant, exp_wr, exp_in);
      end
      if (wr_en) $display("reset_release c%0d: write grant=%b data=%h", c, grant, in);
    end
  endtask

  task automatic test_two_producers();
    logic [3:0] exp_grant;
    logic [7:0] exp_in;
    logic       idle;
    int         owner;
    int         words;
    req_valid = 4'b0000;
    do_reset();
    pdata[0] = 8'hA0;
    pdata[2] = 8'hA2;
    req_valid = 4'b0101;
    words = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge wr_clk);
      idle      = (c % 5 == 0);
      owner     = ((c / 5) % 2 == 0) ? 0 : 2;
      exp_grant = idle ? 4'b0000 : 4'(1 << owner);
      exp_in    = idle ? 8'h00 : pdata[owner];
      checks++;
      if (grant !== exp_grant || wr_en !== !idle || in !== exp_in ||
          req_ready !== exp_grant) begin
        errors++;
        $display("FAIL two_producers c%0d: grant=%b wr_en=%b in=%h ready=%b required grant=%b wr_en=%b in=%h",
                 c, grant, wr_en, in, req_ready, exp_grant, !idle, exp_in);
      end
      if (wr_en) begin
        words++;
        $display("two_producers c%0d: write grant=%b data=%h", c, grant, in);
      end
      @(posedge wr_clk);
      #1;
    end
    checks++;
    if (words != 12) begin
      errors++;
      $display("FAIL two_producers_rate: words=%0d required 12 in 15 cycles", words);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_grant;
    logic       exp_wr;
    req_valid = 4'b0000;
    do_reset();
    pdata[1] = 8'hB1;
    req_valid = 4'b0010;
    for (int c = 0; c <= 12; c++) begin
      full = (c >= 3 && c <= 8);
      @(negedge wr_clk);
      exp_wr    = (c == 1 || c == 2 || c == 9 || c == 10 || c == 12);
      exp_grant = (c == 0 || c == 11) ? 4'b0000 : 4'b0010;
      checks++;
      if (grant !== exp_grant || wr_en !== exp_wr || req_ready !== (exp_wr ? 4'b0010 : 4'b0000) ||
          busy !== (exp_grant != 4'b0000)) begin
        errors++;
        $display("FAIL backpressure c%0d: grant=%b wr_en=%b ready=%b busy=%b full=%b required grant=%b wr_en=%b",
                 c, grant, wr_en, req_ready, busy, full, exp_grant, exp_wr);
      end
      if (wr_en) $display("backpressure c%0d: write grant=%b data=%h", c, grant, in);
      @(posedge wr_clk);
      #1;
    end
    full = 1'b0;
  endtask

  task automatic test_drop_wrap();
    logic [3:0] exp_grant;
    logic       exp_wr;
    req_valid = 4'b0000;
    do_reset();
    pdata[3] = 8'hC3;
    pdata[0] = 8'hC0;
    for (int c = 0; c <= 4; c++) begin
      req_valid = (c < 2) ? 4'b1000 : 4'b0001;
      @(negedge wr_clk);
      exp_wr    = (c == 1 || c == 4);
      exp_grant = (c == 1 || c == 2) ? 4'b1000 : (c == 4 ? 4'b0001 : 4'b0000);
      checks++;
      if (grant !== exp_grant || wr_en !== exp_wr || req_ready !== (exp_wr ? exp_grant : 4'b0000) ||
          (exp_wr && in !== (c == 1 ? 8'hC3 : 8'hC0))) begin
        errors++;
        $display("FAIL drop_wrap c%0d: grant=%b wr_en=%b ready=%b in=%h required grant=%b wr_en=%b",
                 c, grant, wr_en, req_ready, in, exp_grant, exp_wr);
      end
      if (wr_en) $display("drop_wrap c%0d: write grant=%b data=%h", c, grant, in);
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b0000;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'hD0 + 8'(i);
    req_valid = 4'b1111;
    repeat (7) @(negedge wr_clk);
    checks++;
    if (grant !== 4'b0010 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst_setup: grant=%b wr_en=%b required grant=0010 wr_en=1", grant, wr_en);
    end
    #1 wr_reset_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000 || in !== 8'h00) begin
      errors++;
      $display("FAIL mid_burst_reset: wr_en=%b grant=%b busy=%b ready=%b in=%h required all zero",
               wr_en, grant, busy, req_ready, in);
    end
    @(posedge wr_clk);
    #1 wr_reset_n = 1'b1;
    @(negedge wr_clk);
    checks++;
    if (grant !== 4'b0000 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_burst_idle: grant=%b wr_en=%b required 0000 0", grant, wr_en);
    end
    @(negedge wr_clk);
    checks++;
    if (grant !== 4'b0001 || wr_en !== 1'b1 || in !== 8'hD0) begin
      errors++;
      $display("FAIL mid_burst_regrant: grant=%b wr_en=%b in=%h required 0001 1 d0", grant, wr_en, in);
    end
    $display("mid_burst_reset: regrant grant=%b data=%h", grant, in);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0]   exp_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] has_word;
    logic [NUM_REQ-1:0] accepted;
    logic [3:0]         exp_grant;
    logic               exp_wr;
    logic [WIDTH-1:0]   exp_in;
    int                 owner;
    int                 rr_model;
    int                 beats;
    int                 full_left;
    int                 pick;
    req_valid = 4'b0000;
    do_reset();
    has_word  = '0;
    exp_grant = 4'b0000;
    owner     = 0;
    rr_model  = 0;
    beats     = 0;
    full_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge wr_clk);
      exp_wr = (exp_grant != 4'b0000) && req_valid[owner] && !full;
      checks++;
      if (grant !== exp_grant || wr_en !== exp_wr || req_ready !== (exp_wr ? exp_grant : 4'b0000) ||
          busy !== (exp_grant != 4'b0000)) begin
        errors++;
        $display("FAIL random c%0d: grant=%b wr_en=%b ready=%b busy=%b full=%b valid=%b required grant=%b wr_en=%b",
                 cyc, grant, wr_en, req_ready, busy, full, req_valid, exp_grant, exp_wr);
      end
      if (exp_wr && wr_en === 1'b1 && exp_q[owner].size() > 0) begin
        exp_in = exp_q[owner].pop_front();
        checks++;
        if (in !== exp_in) begin
          errors++;
          $display("FAIL random_data c%0d p%0d: in=%h required %h", cyc, owner, in, exp_in);
        end
        $display("random c%0d: write p%0d data=%h", cyc, owner, in);
      end
      if (exp_wr) beats++;
      if (exp_grant == 4'b0000) begin
        pick = rr_pick(rr_model, req_valid);
        if (pick >= 0) begin
          owner     = pick;
          exp_grant = 4'(1 << pick);
          beats     = 0;
        end
      end else if (!req_valid[owner] || (exp_wr && beats == MAX_BURST)) begin
        exp_grant = 4'b0000;
        rr_model  = (owner + 1) % NUM_REQ;
      end
      accepted = req_valid & req_ready;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accepted[i]) has_word[i] = 1'b0;
        if (!has_word[i] && $urandom_range(0, 9) < 6) begin
          pdata[i] = 8'($urandom);
          exp_q[i].push_back(pdata[i]);
          has_word[i] = 1'b1;
        end
        req_valid[i] = has_word[i] && ($urandom_range(0, 7) != 0);
      end
      if (full_left > 0) full_left--;
      else if ($urandom_range(0, 7) == 0) full_left = $urandom_range(1, 6);
      full = (full_left > 0);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (exp_q[i].size() > 1) begin
        errors++;
        $display("FAIL random_drain p%0d: unwritten=%0d required at most 1", i, exp_q[i].size());
      end
    end
    full = 1'b0;
    req_valid = 4'b0000;
  endtask

  initial begin
    wr_reset_n = 1'b0;
    req_valid  = 4'b0000;
    full       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'h00;
    test_reset();
    test_two_producers();
    test_backpressure();
    test_drop_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
